neuron_accum: RTL and testbench
===============================

NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 8, signed accumulator/bias width (range 6..16).
REQ-002 SHALL have parameter PACK, default 6, activations per output word (matches 6-bit downstream x_i).
REQ-003 SHALL have port sync_clk  in  1  digit-synchronous clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  y_ij beat valid.
REQ-006 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port y_ij  in  4  signed two's-complement partial dot-product from dotproduct stage.
REQ-008 SHALL have port in_last  in  1  marks final beat of current neuron.
REQ-009 SHALL have port bias  in  ACC_W  signed neuron bias, sampled on the in_last beat.
REQ-010 SHALL have port flush  in  1  single-cycle request to emit a partially filled word.
REQ-011 SHALL have port out_valid  out  1  act_word valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts word when out_valid && out_ready.
REQ-013 SHALL have port act_word  out  PACK  packed binary activations.
REQ-014 SHALL have port act_cnt  out  3  number of valid bits in act_word (PACK, or fewer after flush).

Function
REQ-015 SHALL sign-extend y_ij to ACC_W and add it to acc on every accepted beat; non-accepted cycles SHALL leave acc unchanged.
REQ-016 On accepted in_last beat, SHALL compute sum = acc + y_ij + bias, saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; all intermediate additions SHALL saturate identically.
REQ-017 Activation bit SHALL be 1 when sum >= 0, else 0; acc SHALL clear to 0 in the same cycle the activation is latched.
REQ-018 Activation k of a word (k = 0 first) SHALL occupy act_word[k]; unfilled bits SHALL be 0.
REQ-019 SHALL use FSM states FILL (collecting activations) and HOLD (word presented); reset state FILL.
REQ-020 FILL->HOLD when the PACK-th activation is latched, or when flush is high with pack count > 0; out_valid SHALL assert the cycle after that edge (latency 1 from final in_last beat).
REQ-021 HOLD->FILL on out_valid && out_ready; pack count and pack register SHALL clear in that cycle.
REQ-022 in_ready SHALL be 1 in FILL and 0 in HOLD; act_word, act_cnt SHALL be stable while out_valid && !out_ready.
REQ-023 flush with pack count 0 SHALL be ignored; flush coincident with an accepted in_last beat SHALL include that beat's activation in the emitted word.
REQ-024 A neuron with only one beat (in_valid && in_last) SHALL be legal.

Reset
REQ-025 rst SHALL clear acc, pack register, pack count, act_word, act_cnt to 0, out_valid to 0, state to FILL; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-026 rst mid-neuron or in HOLD SHALL discard all partial sums and the held word with no out_valid pulse.

Configuration
REQ-027 With NEURON_SUM_DBG_EN defined, SHALL add outputs sum_valid (1) and sum_o (ACC_W), pulsing sum_valid for one cycle with the saturated sum on each activation latch; without it these ports SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-028 Shared package nn_pkg SHALL hold ACC_W/PACK defaults, y_ij width (4), and FSM state encoding.
REQ-029 Saturating adder SHALL be a sub-module sat_add (parameter width W; signed a, b; signed saturated out), instantiated for acc and final bias add.

Verification
REQ-030 Bias 0, beats y=6,6,-2 (last) -> sum 10, bit 1; six such neurons -> act_word 6'b111111, act_cnt 6, out_valid one cycle after sixth last.
REQ-031 Bias -11, beats y=7,3 (last) -> sum -1, bit 0; bias -10 same beats -> sum 0, bit 1 (zero boundary).
REQ-032 ACC_W 8, bias 127, twenty beats y=7 -> sum saturates 127, no wrap; twenty beats y=-8 bias -128 -> -128, bit 0.
REQ-033 Three neurons (1,0,1) then flush -> act_word 6'b000101, act_cnt 3; flush with count 0 -> no out_valid.
REQ-034 Word held with out_ready=0 for 5 cycles -> in_ready 0, act_word stable, in_valid beats ignored; out_ready=1 -> FILL next cycle.
REQ-035 rst asserted after 3 beats mid-neuron -> next neuron with bias 0, y=-1 last yields bit 0 (no stale acc).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron accumulator: default widths and FSM state encoding.
package nn_pkg;

  localparam int NN_ACC_W = 8;
  localparam int NN_PACK  = 6;
  localparam int NN_Y_W   = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder that clamps to the representable range instead of wrapping.
module sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  logic signed [W:0] full;

  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    sum  = full[W-1:0];
    // Overflow shows up as disagreement between the guard bit and the result sign.
    if (full[W] != full[W-1]) begin
      sum = full[W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/neuron_accum.sv
// Accumulates signed partial dot products per neuron, adds bias, and packs sign activations into words.
// Optional debug outputs sum_valid/sum_o are enabled with NEURON_SUM_DBG_EN.
module neuron_accum
  import nn_pkg::*;
#(
  parameter int ACC_W = NN_ACC_W,
  parameter int PACK  = NN_PACK
) (
  input  logic                     sync_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [NN_Y_W-1:0] y_ij,
  input  logic                     in_last,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACK-1:0]          act_word,
  output logic [2:0]               act_cnt
`ifdef NEURON_SUM_DBG_EN
  ,
  output logic                     sum_valid,
  output logic signed [ACC_W-1:0]  sum_o
`endif
);

  localparam logic [2:0]              PACK_CNT = 3'(PACK);
  localparam logic signed [ACC_W-1:0] ZERO     = '0;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PACK-1:0]         pack_q, pack_d;
  logic [2:0]              cnt_q, cnt_d;

  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] acc_plus_y;
  logic signed [ACC_W-1:0] sum;
  logic [PACK-1:0]         act_vec;
  logic                    accept;
  logic                    latch;
  logic                    act_bit;

  assign y_ext   = {{(ACC_W-NN_Y_W){y_ij[NN_Y_W-1]}}, y_ij};
  assign act_bit = (sum >= ZERO);
  assign act_vec = {{(PACK-1){1'b0}}, act_bit};

  sat_add #(.W(ACC_W)) u_acc_add (
    .a   (acc_q),
    .b   (y_ext),
    .sum (acc_plus_y)
  );

  sat_add #(.W(ACC_W)) u_bias_add (
    .a   (acc_plus_y),
    .b   (bias),
    .sum (sum)
  );

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign act_word  = pack_q;
  assign act_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pack_d  = pack_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last) begin
            latch  = 1'b1;
            acc_d  = '0;
            pack_d = pack_q | (act_vec << cnt_q);
            cnt_d  = cnt_q + 3'd1;
          end else begin
            acc_d = acc_plus_y;
          end
        end
        // A flush on the same beat as the last activation still sees the updated count.
        if (latch && (cnt_d == PACK_CNT)) begin
          state_d = HOLD;
        end else if (flush && (cnt_d != 3'd0)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          pack_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge sync_clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      pack_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef NEURON_SUM_DBG_EN
  logic                    sum_valid_q, sum_valid_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_valid_d = latch;
    sum_d       = latch ? sum : sum_q;
  end

  always_ff @(posedge sync_clk) begin
    if (rst) begin
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      sum_valid_q <= sum_valid_d;
      sum_q       <= sum_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_o     = sum_q;
`endif

endmodule

// File: tb/tb_neuron_accum.sv
// Directed, table-driven bench for neuron_accum: activation packing, saturation, flush, hold and reset.
module tb_neuron_accum;

  logic              sync_clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] y_ij;
  logic              in_last;
  logic signed [7:0] bias;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        act_word;
  logic [2:0]        act_cnt;
`ifdef NEURON_SUM_DBG_EN
  logic              sum_valid;
  logic signed [7:0] sum_o;
`endif

  always #5 sync_clk = ~sync_clk;

  neuron_accum dut (
    .sync_clk  (sync_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_ij      (y_ij),
    .in_last   (in_last),
    .bias      (bias),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .act_word  (act_word),
    .act_cnt   (act_cnt)
`ifdef NEURON_SUM_DBG_EN
    ,
    .sum_valid (sum_valid),
    .sum_o     (sum_o)
`endif
  );

  typedef struct {
    int                n;
    logic signed [3:0] y0;
    logic signed [3:0] y1;
    logic signed [3:0] y2;
    logic signed [7:0] b;
    logic              exp_bit;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int n, input int y0, input int y1, input int y2,
                              input int b, input logic e);
    vec_t v;
    v.n       = n;
    v.y0      = 4'(y0);
    v.y1      = 4'(y1);
    v.y2      = 4'(y2);
    v.b       = 8'(b);
    v.exp_bit = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge sync_clk);
    @(negedge sync_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One beat, presented for a single clock edge.
  task automatic applyStimulus(input logic signed [3:0] y, input logic last,
                               input logic signed [7:0] b, input logic fl);
    in_valid = 1'b1;
    y_ij     = y;
    in_last  = last;
    bias     = b;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic sendRepeat(input int n, input logic signed [3:0] y,
                            input logic signed [7:0] b);
    for (int i = 0; i < n; i++) begin
      applyStimulus(y, (i == n - 1), b, 1'b0);
    end
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic releaseWord(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_rel_in_ready"}, 32'(in_ready), 1);
    checkOutput({tag, "_rel_out_valid"}, 32'(out_valid), 0);
  endtask

  task automatic checkWord(input string tag, input logic [5:0] w, input logic [2:0] c);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, "_act_word"}, 32'(act_word), 32'(w));
    checkOutput({tag, "_act_cnt"}, 32'(act_cnt), 32'(c));
  endtask

  initial begin
    #100000;
    n_err++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0]        exp_word;
    int                k;
    logic signed [3:0] yb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    y_ij      = '0;
    in_last   = 1'b0;
    bias      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge sync_clk);
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 0);
    checkOutput("post_rst_act_word", 32'(act_word), 0);
    checkOutput("post_rst_act_cnt", 32'(act_cnt), 0);

    // Hand-computed sums: 10, -1, 0, -1, 0, -1 then six copies of 10.
    vecs[0]  = mk(3, 6, 6, -2, 0, 1'b1);
    vecs[1]  = mk(2, 7, 3, 0, -11, 1'b0);
    vecs[2]  = mk(2, 7, 3, 0, -10, 1'b1);
    vecs[3]  = mk(1, -1, 0, 0, 0, 1'b0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 1'b1);
    vecs[5]  = mk(3, -8, -8, -8, 23, 1'b0);
    for (int i = 6; i < 12; i++) vecs[i] = mk(3, 6, 6, -2, 0, 1'b1);

    exp_word = '0;
    k        = 0;
    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < vecs[i].n; b++) begin
        yb = (b == 0) ? vecs[i].y0 : ((b == 1) ? vecs[i].y1 : vecs[i].y2);
        applyStimulus(yb, (b == vecs[i].n - 1), vecs[i].b, 1'b0);
      end
      exp_word[k] = vecs[i].exp_bit;
      k++;
      if (k == 6) begin
        checkWord($sformatf("vec%0d_word", i), exp_word, 3'd6);
        releaseWord($sformatf("vec%0d", i));
        exp_word = '0;
        k        = 0;
      end else begin
        checkOutput($sformatf("vec%0d_no_valid", i), 32'(out_valid), 0);
      end
    end

    // Saturation: 127+127 -> 127; -128-128 -> -128; 20*7 -> 127; 20*(-8) -> -128.
    sendRepeat(20, 4'sd7, 8'sd127);
    sendRepeat(20, -4'sd8, -8'sd128);
    sendRepeat(20, 4'sd7, 8'sd0);
    sendRepeat(20, -4'sd8, 8'sd0);
    checkOutput("sat_no_valid", 32'(out_valid), 0);
    pulseFlush();
    checkWord("sat_word", 6'b000101, 3'd4);

    // Word held with out_ready low; non-last beats offered meanwhile must be ignored.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      y_ij     = -4'sd8;
      in_last  = 1'b0;
      bias     = 8'sd0;
      tick();
      checkWord($sformatf("hold%0d", c), 6'b000101, 3'd4);
    end
    in_valid = 1'b0;
    releaseWord("hold");

    sendRepeat(1, 4'sd0, 8'sd0);
    sendRepeat(1, -4'sd1, 8'sd0);
    sendRepeat(1, 4'sd0, 8'sd0);
    checkOutput("partial_no_valid", 32'(out_valid), 0);
    pulseFlush();
    checkWord("flush3", 6'b000101, 3'd3);
    releaseWord("flush3");

    pulseFlush();
    checkOutput("flush_empty_no_valid", 32'(out_valid), 0);
    tick();
    checkOutput("flush_empty_no_valid2", 32'(out_valid), 0);

    applyStimulus(-4'sd1, 1'b1, 8'sd0, 1'b1);
    checkWord("flush_with_last", 6'b000000, 3'd1);
    releaseWord("flush_with_last");
    applyStimulus(4'sd0, 1'b1, 8'sd0, 1'b1);
    checkWord("flush_with_last2", 6'b000001, 3'd1);
    releaseWord("flush_with_last2");

    // Reset mid-neuron must drop the partial sum of 21.
    applyStimulus(4'sd7, 1'b0, 8'sd0, 1'b0);
    applyStimulus(4'sd7, 1'b0, 8'sd0, 1'b0);
    applyStimulus(4'sd7, 1'b0, 8'sd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 1);
    sendRepeat(1, -4'sd1, 8'sd0);
    pulseFlush();
    checkWord("mid_rst_word", 6'b000000, 3'd1);
    releaseWord("mid_rst");

    sendRepeat(1, 4'sd0, 8'sd0);
    pulseFlush();
    checkWord("pre_hold_rst", 6'b000001, 3'd1);
    rst = 1'b1;
    tick();
    checkOutput("hold_rst_out_valid", 32'(out_valid), 0);
    checkOutput("hold_rst_act_word", 32'(act_word), 0);
    checkOutput("hold_rst_act_cnt", 32'(act_cnt), 0);
    rst = 1'b0;
    tick();
    checkOutput("hold_rst_in_ready", 32'(in_ready), 1);
    checkOutput("hold_rst_no_valid", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
